// File: rtl/result_stream_fpga2hps.sv
// Streams the n*n valid bytes of a captured 200-bit result matrix to the HPS over valid/ready.
// Optional RESULT_STREAM_CHECKSUM_EN appends one XOR checksum beat after the last element.
module result_stream_fpga2hps #(
    parameter int ELEM_W = 8,
    parameter int MAT_W  = 200
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [MAT_W-1:0]  matrix_in,
    input  logic [1:0]        size,
    output logic              busy,
    output logic [ELEM_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              data_last,
    output logic              done
);
    localparam int N_ELEM = MAT_W / ELEM_W;

`ifdef RESULT_STREAM_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CHK = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t             state_reg, state_next;
    logic [4:0]         idx_reg, idx_next;
    logic [4:0]         last_idx_reg, last_idx_next;
    logic [MAT_W-1:0]   shadow_reg, shadow_next;
    logic [ELEM_W-1:0]  elem [N_ELEM];
`ifdef RESULT_STREAM_CHECKSUM_EN
    logic [ELEM_W-1:0]  csum_reg, csum_next;
`endif

    // Row-major view of the shadow register: element 0 sits in the top byte.
    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
            assign elem[gi] = shadow_reg[MAT_W-1-ELEM_W*gi -: ELEM_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            last_idx_reg <= '0;
            shadow_reg   <= '0;
`ifdef RESULT_STREAM_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            last_idx_reg <= last_idx_next;
            shadow_reg   <= shadow_next;
`ifdef RESULT_STREAM_CHECKSUM_EN
            csum_reg     <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        last_idx_next = last_idx_reg;
        shadow_next   = shadow_reg;
`ifdef RESULT_STREAM_CHECKSUM_EN
        csum_next     = csum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (load) begin
                    state_next  = SEND;
                    shadow_next = matrix_in;
                    idx_next    = '0;
`ifdef RESULT_STREAM_CHECKSUM_EN
                    csum_next   = '0;
`endif
                    // last index = (size+2)^2 - 1
                    case (size)
                        2'b00:   last_idx_next = 5'd3;
                        2'b01:   last_idx_next = 5'd8;
                        2'b10:   last_idx_next = 5'd15;
                        default: last_idx_next = 5'd24;
                    endcase
                end
            end
            SEND: begin
                if (data_ready) begin
`ifdef RESULT_STREAM_CHECKSUM_EN
                    csum_next = csum_reg ^ elem[idx_reg];
`endif
                    if (idx_reg == last_idx_reg) begin
                        idx_next = '0;
`ifdef RESULT_STREAM_CHECKSUM_EN
                        state_next = CHK;
`else
                        state_next = DONE;
`endif
                    end else begin
                        idx_next = idx_reg + 5'd1;
                    end
                end
            end
`ifdef RESULT_STREAM_CHECKSUM_EN
            CHK: begin
                if (data_ready) state_next = DONE;
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every output is a decode of registered state, so ready never reaches valid combinationally.
    always_comb begin
        busy       = (state_reg != IDLE);
        data_valid = 1'b0;
        data_out   = '0;
        data_last  = 1'b0;
        done       = (state_reg == DONE);
        if (state_reg == SEND) begin
            data_valid = 1'b1;
            data_out   = elem[idx_reg];
`ifndef RESULT_STREAM_CHECKSUM_EN
            data_last  = (idx_reg == last_idx_reg);
`endif
        end
`ifdef RESULT_STREAM_CHECKSUM_EN
        if (state_reg == CHK) begin
            data_valid = 1'b1;
            data_out   = csum_reg;
            data_last  = 1'b1;
        end
`endif
    end

endmodule
